pipe_adder: RTL



---
 rtl/pipe_adder_pkg.sv | 39 +++
 rtl/pipe_adder_chunk_adder.sv | 35 +++
 rtl/pipe_adder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared definitions for the pipelined adder slice.
//   DEFAULT_WIDTH / DEFAULT_STAGES / DEFAULT_CHUNK : default geometry
//   stage_ctl_t   : per-stage control record (valid flag, carry out)
//   make_ctl      : constructor for stage_ctl_t
//   chunk_size    : WIDTH/STAGES, or 0 when the split is not exact
//   stage0_carry  : carry fed into the lowest chunk (sub forces 1)
package pipe_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32;
    localparam int unsigned DEFAULT_STAGES = 4;
    localparam int unsigned DEFAULT_CHUNK  = DEFAULT_WIDTH / DEFAULT_STAGES;

    typedef struct packed {
        logic valid;
        logic carry;
    } stage_ctl_t;

    function automatic stage_ctl_t make_ctl(input logic valid, input logic carry);
        stage_ctl_t ctl;
        ctl.valid = valid;
        ctl.carry = carry;
        return ctl;
    endfunction

    // Returns 0 for an illegal split so the top can raise an elaboration error.
    function automatic int unsigned chunk_size(input int unsigned width,
                                               input int unsigned stages);
        if (stages == 0 || (width % stages) != 0) begin
            return 0;
        end
        return width / stages;
    endfunction

    // Subtraction is a + ~b + 1, so the incoming carry is forced high.
    function automatic logic stage0_carry(input logic sub, input logic cin);
        return sub ? 1'b1 : cin;
    endfunction

endpackage

// File: rtl/pipe_adder_chunk_adder.sv
// chunk_adder: CHUNK-bit combinational ripple-carry adder.
//   a, b  : CHUNK-bit operands
//   cin   : carry into bit 0
//   s     : CHUNK-bit sum
//   cout  : carry out of bit CHUNK-1
//   cmsb  : carry into bit CHUNK-1 (used for signed overflow)
module chunk_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    always_comb begin : p_ripple
        logic carry;
        carry = cin;
        s     = '0;
        cmsb  = cin;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            if (i == CHUNK - 1) begin
                cmsb = carry;
            end
            s[i]  = a[i] ^ b[i] ^ carry;
            carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: elastically pipelined ripple-carry adder/subtractor.
// A WIDTH-bit add is split into STAGES chunks of CHUNK bits; each stage adds
// one chunk and registers the carry, so one result per cycle with latency
// STAGES. Valid/ready handshakes on both sides.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid, in_ready  : operand beat handshake
//   a, b, cin, sub      : operands; sub=1 gives a-b (cin ignored)
//   out_valid, out_ready: result handshake
//   s, cout             : result and carry out of the MSB (sub: 1 = no borrow)
//   ovf                 : signed overflow, present only with PIPE_ADDER_OVF_EN
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout
`ifdef PIPE_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned CHUNK = chunk_size(WIDTH, STAGES);
    localparam int unsigned LAST  = STAGES - 1;

    if (CHUNK == 0) begin : g_bad_cfg
        $error("pipe_adder: WIDTH must be a non-zero multiple of STAGES");
    end

    logic [WIDTH-1:0]              b_eff;
    logic [STAGES-1:0][WIDTH-1:0]  src_acc;
    logic [STAGES-1:0][WIDTH-1:0]  src_b;
    logic [STAGES-1:0][WIDTH-1:0]  nxt_acc;
    logic [STAGES-1:0][WIDTH-1:0]  acc_r;
    logic [STAGES-1:0][WIDTH-1:0]  b_r;
    logic [STAGES-1:0][CHUNK-1:0]  sum_c;
    logic [STAGES-1:0]             src_v;
    logic [STAGES-1:0]             src_c;
    logic [STAGES-1:0]             ld;
    logic [STAGES-1:0]             co;
    logic [STAGES-1:0]             cm;
    stage_ctl_t [STAGES-1:0]       ctl_r;
    logic                          unused_bits;

    assign b_eff = sub ? ~b : b;

    // Stage k works on the record held by stage k-1; stage 0 on the new beat.
    // acc carries finished low chunks plus still-unadded upper chunks of a.
    always_comb begin : p_src
        src_acc    = '0;
        src_b      = '0;
        src_c      = '0;
        src_v      = '0;
        src_acc[0] = a;
        src_b[0]   = b_eff;
        src_c[0]   = stage0_carry(sub, cin);
        src_v[0]   = in_valid;
        for (int unsigned k = 1; k < STAGES; k++) begin
            src_acc[k] = acc_r[k-1];
            src_b[k]   = b_r[k-1];
            src_c[k]   = ctl_r[k-1].carry;
            src_v[k]   = ctl_r[k-1].valid;
        end
    end

    // Load enables ripple back from the output: a stage loads when it is
    // empty or its successor is loading, so bubbles collapse under stall.
    always_comb begin : p_adv
        logic next_ld;
        next_ld = out_ready;
        ld      = '0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            next_ld      = !ctl_r[LAST-i].valid || next_ld;
            ld[LAST-i]   = next_ld;
        end
    end

    assign in_ready = ld[0] && !rst;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        chunk_adder #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a    (src_acc[k][k*CHUNK +: CHUNK]),
            .b    (src_b[k][k*CHUNK +: CHUNK]),
            .cin  (src_c[k]),
            .s    (sum_c[k]),
            .cout (co[k]),
            .cmsb (cm[k])
        );
    end

    always_comb begin : p_merge
        nxt_acc = src_acc;
        for (int unsigned k = 0; k < STAGES; k++) begin
            nxt_acc[k][k*CHUNK +: CHUNK] = sum_c[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctl_r <= '0;
            acc_r <= '0;
            b_r   <= '0;
        end else begin
            for (int unsigned k = 0; k < STAGES; k++) begin
                if (ld[k]) begin
                    ctl_r[k] <= make_ctl(src_v[k], co[k]);
                    acc_r[k] <= nxt_acc[k];
                    b_r[k]   <= src_b[k];
                end
            end
        end
    end

    assign out_valid = ctl_r[LAST].valid;
    assign s         = acc_r[LAST];
    assign cout      = ctl_r[LAST].carry;

    // Intermediate MSB-carries and the final stage's operand copy are dead.
    assign unused_bits = ^{cm, b_r[LAST]};

`ifdef PIPE_ADDER_OVF_EN
    logic cmsb_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            cmsb_r <= 1'b0;
        end else if (ld[LAST]) begin
            cmsb_r <= cm[LAST];
        end
    end

    assign ovf = cmsb_r ^ cout;
`endif

endmodule
